// File: rtl/instr_cache_nway.sv
// N-way set-associative instruction cache with round-robin replacement,
// same-cycle hits and sequential block refill over the AHB-style bus.
module instr_cache_nway #(
  parameter int unsigned blocksize = 4,
  parameter int unsigned lines     = 2,
  parameter int unsigned ways      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic        Invalidate,
  input  logic        BusReady,
  input  logic [31:0] HRData,
  output logic [31:0] RD,
  output logic [31:0] HAddrF,
  output logic        HRequestF,
  output logic        IStall
);

  localparam int unsigned SETBITS   = $clog2(lines);
  localparam int unsigned BLOCKBITS = $clog2(blocksize);
  localparam int unsigned TAGBITS   = 30 - BLOCKBITS - SETBITS;
  localparam int unsigned WAYBITS   = $clog2(ways);
  localparam int unsigned SETW      = (SETBITS > 0) ? SETBITS : 1;
  localparam int unsigned WAYW      = (WAYBITS > 0) ? WAYBITS : 1;

  typedef enum logic {
    LOOKUP = 1'b0,
    FILL   = 1'b1
  } state_t;

  state_t               state_q;
  logic [BLOCKBITS-1:0] cnt_q;
  logic [WAYW-1:0]      victim_q;
  logic [WAYW-1:0]      vptr_q  [lines];
  logic [ways-1:0]      valid_q [lines];
  logic [TAGBITS-1:0]   tag_q   [lines][ways];
  logic [31:0]          data_q  [lines][ways][blocksize];

  logic [TAGBITS-1:0]   tag_a;
  logic [SETW-1:0]      set_a;
  logic [BLOCKBITS-1:0] word_a;
  logic [ways-1:0]      match;
  logic                 hit;
  logic [WAYW-1:0]      hit_way;
  logic                 last_beat;
  logic                 beat;

  assign tag_a  = A[31 -: TAGBITS];
  assign word_a = A[2 +: BLOCKBITS];

  if (SETBITS > 0) begin : g_set
    assign set_a = A[BLOCKBITS+2 +: SETBITS];
  end else begin : g_noset
    assign set_a = 1'b0;
  end

  for (genvar w = 0; w < int'(ways); w++) begin : g_match
    assign match[w] = valid_q[set_a][w] && (tag_q[set_a][w] == tag_a);
  end

  // Lowest matching way wins; a duplicate match should never happen.
  always_comb begin
    hit     = |match;
    hit_way = '0;
    for (int w = int'(ways) - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAYW'(w);
    end
  end

  assign beat      = (state_q == FILL) && BusReady && !Invalidate;
  assign last_beat = (cnt_q == BLOCKBITS'(blocksize - 1));

  always_comb begin
    RD        = data_q[set_a][hit_way][word_a];
    HAddrF    = A;
    HRequestF = 1'b0;
    IStall    = reset || !hit;
    if (state_q == FILL) begin
      RD        = HRData;
      HAddrF    = {A[31:BLOCKBITS+2], cnt_q, 2'b00};
      HRequestF = !reset;
      IStall    = 1'b1;
    end
  end

  // Control: FSM, beat counter, valid bits and victim pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOOKUP;
      cnt_q    <= '0;
      victim_q <= '0;
      for (int s = 0; s < int'(lines); s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else begin
      if (Invalidate) begin
        for (int s = 0; s < int'(lines); s++) valid_q[s] <= '0;
      end
      case (state_q)
        LOOKUP: begin
          if (!hit) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            victim_q <= vptr_q[set_a];
          end
        end
        FILL: begin
          if (Invalidate) begin
            state_q <= LOOKUP;
            cnt_q   <= '0;
          end else if (BusReady) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              valid_q[set_a][victim_q] <= 1'b1;
              vptr_q[set_a]            <= (ways > 1) ? WAYW'(victim_q + 1'b1) : '0;
              state_q                  <= LOOKUP;
            end
          end
        end
        default: state_q <= LOOKUP;
      endcase
    end
  end

  // Tag and data arrays carry no reset; only valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!reset && beat) begin
      data_q[set_a][victim_q][cnt_q] <= HRData;
      if (last_beat) tag_q[set_a][victim_q] <= tag_a;
    end
  end

endmodule

// File: tb/tb_instr_cache_nway.sv
// Scoreboard bench for instr_cache_nway: directed fetch vectors on a 2-way
// instance plus random address streams on two other parameterisations.
module tb_instr_cache_nway;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic        Invalidate = 1'b0;
  logic        BusReady = 1'b0;
  logic [31:0] HRData;
  logic [31:0] RD;
  logic [31:0] HAddrF;
  logic        HRequestF;
  logic        IStall;

  logic        sw_reset = 1'b0;
  logic [31:0] s_a      [2];
  logic        s_br     [2];
  logic [31:0] s_hrdata [2];
  logic [31:0] s_rd     [2];
  logic [31:0] s_haddr  [2];
  logic        s_hreq   [2];
  logic        s_istall [2];
  logic        s_req    [2];

  typedef struct {
    logic [31:0] a;
    logic [31:0] rd;
    int          stall;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  exp_t        e;
  logic [31:0] ea;

  int          tests = 0;
  int          fails = 0;
  logic        req = 1'b0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_a = '0;
  logic [7:0]  lowmask = '0;
  int          fill_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign HRData      = mem_word(HAddrF);
  assign s_hrdata[0] = mem_word(s_haddr[0]);
  assign s_hrdata[1] = mem_word(s_haddr[1]);

  instr_cache_nway #(.blocksize(4), .lines(2), .ways(2)) dut (
    .clk(clk), .reset(reset), .A(A), .Invalidate(Invalidate),
    .BusReady(BusReady), .HRData(HRData), .RD(RD), .HAddrF(HAddrF),
    .HRequestF(HRequestF), .IStall(IStall)
  );

  instr_cache_nway #(.blocksize(8), .lines(4), .ways(1)) dut_w1 (
    .clk(clk), .reset(sw_reset), .A(s_a[0]), .Invalidate(1'b0),
    .BusReady(s_br[0]), .HRData(s_hrdata[0]), .RD(s_rd[0]), .HAddrF(s_haddr[0]),
    .HRequestF(s_hreq[0]), .IStall(s_istall[0])
  );

  instr_cache_nway #(.blocksize(2), .lines(1), .ways(4)) dut_w4 (
    .clk(clk), .reset(sw_reset), .A(s_a[1]), .Invalidate(1'b0),
    .BusReady(s_br[1]), .HRData(s_hrdata[1]), .RD(s_rd[1]), .HAddrF(s_haddr[1]),
    .HRequestF(s_hreq[1]), .IStall(s_istall[1])
  );

  // Bus responders: main bus follows lowmask per fill cycle, sweep buses are random.
  always @(posedge clk) begin
    #2;
    if (HRequestF) begin
      BusReady = (fill_cyc < 8) ? !lowmask[fill_cyc[2:0]] : 1'b1;
      fill_cyc++;
    end else begin
      BusReady = 1'b0;
      fill_cyc = 0;
    end
    for (int k = 0; k < 2; k++) s_br[k] = s_hreq[k] && ($urandom_range(0, 3) != 0);
  end

  // Monitors: fetch responses, accepted bus beats, sweep responses.
  always @(negedge clk) begin
    if (req && prev_stall && (A !== prev_a)) begin
      fails++;
      $display("FAIL a_stable: A=%h changed from %h while IStall=1", A, prev_a);
    end
    prev_stall = req && IStall;
    prev_a     = A;

    if (req) begin
      if (IStall) begin
        stall_cnt++;
      end else if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL fetch_unexpected: A=%h RD=%h with empty scoreboard", A, RD);
      end else begin
        e = sb_q.pop_front();
        tests += 3;
        if (RD !== e.rd) begin
          fails++;
          $display("FAIL fetch_rd A=%h: got %h expected %h", e.a, RD, e.rd);
        end
        if (stall_cnt != e.stall) begin
          fails++;
          $display("FAIL fetch_stall A=%h: got %0d cycles expected %0d", e.a, stall_cnt, e.stall);
        end
        if (HAddrF !== e.a) begin
          fails++;
          $display("FAIL lookup_haddr: got %h expected %h", HAddrF, e.a);
        end
        stall_cnt = 0;
      end
    end

    if (!reset && HRequestF && BusReady && !Invalidate) begin
      tests++;
      if (addr_q.size() == 0) begin
        fails++;
        $display("FAIL bus_beat_unexpected: HAddrF=%h", HAddrF);
      end else begin
        ea = addr_q.pop_front();
        if (HAddrF !== ea) begin
          fails++;
          $display("FAIL bus_addr: got %h expected %h", HAddrF, ea);
        end
      end
    end

    for (int k = 0; k < 2; k++) begin
      if (!sw_reset && s_req[k] && !s_istall[k]) begin
        tests++;
        if ((k == 0 && exp0_q.size() == 0) || (k == 1 && exp1_q.size() == 0)) begin
          fails++;
          $display("FAIL sweep%0d_unexpected: RD=%h", k, s_rd[k]);
        end else begin
          ea = (k == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
          if (s_rd[k] !== ea) begin
            fails++;
            $display("FAIL sweep%0d_rd A=%h: got %h expected %h", k, s_a[k], s_rd[k], ea);
          end
        end
      end
    end
  end

  task automatic push_beats(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(base + 32'(4 * i));
  endtask

  // Present one fetch and hold A until the cache stops stalling.
  task automatic access(input logic [31:0] a, input int stall);
    int n;
    sb_q.push_back('{a: a, rd: mem_word(a), stall: stall});
    A   = a;
    req = 1'b1;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!IStall) break;
    end
    tests++;
    if (n >= 64) begin
      fails++;
      $display("FAIL fetch_timeout A=%h: IStall still %b after %0d cycles, required 0", a, IStall, n);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] next_a);
    A     = next_a;
    reset = 1'b1;
    @(negedge clk);
    tests += 2;
    if (IStall !== 1'b1) begin
      fails++;
      $display("FAIL reset_istall: got %b expected 1", IStall);
    end
    if (HRequestF !== 1'b0) begin
      fails++;
      $display("FAIL reset_hrequest: got %b expected 0", HRequestF);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_inval();
    Invalidate = 1'b1;
    @(posedge clk); #1;
    Invalidate = 1'b0;
  endtask

  task automatic run_sweep(input int k, input int unsigned nwords);
    logic [31:0] a;
    int n;
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, nwords - 1)) << 2;
      if (k == 0) exp0_q.push_back(mem_word(a));
      else        exp1_q.push_back(mem_word(a));
      s_a[k]   = a;
      s_req[k] = 1'b1;
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (!s_istall[k]) break;
      end
      tests++;
      if (n >= 200) begin
        fails++;
        $display("FAIL sweep%0d_timeout A=%h: still stalled after %0d cycles", k, a, n);
      end
      @(posedge clk); #1;
      s_req[k] = 1'b0;
    end
  endtask

  task automatic directed();
    do_reset(32'h100);
    // Cold miss then hits in the same block.
    push_beats(32'h100, 4); access(32'h100, 5);
    access(32'h108, 0);
    access(32'h104, 0);
    access(32'h10C, 0);
    // Backpressure on fill cycles 1 and 3 stretches the stall by two.
    lowmask = 8'b0000_1010;
    push_beats(32'h300, 4); access(32'h300, 7);
    lowmask = '0;
    access(32'h308, 0);
    // Invalidate drops both resident lines.
    pulse_inval();
    push_beats(32'h100, 4); access(32'h100, 5);
    push_beats(32'h300, 4); access(32'h300, 5);
    access(32'h100, 0);
    // Invalidate on the last beat aborts the fill and forces a re-miss.
    push_beats(32'h110, 3);
    push_beats(32'h110, 4);
    fork
      access(32'h110, 10);
      begin
        repeat (4) @(posedge clk);
        #1 Invalidate = 1'b1;
        @(posedge clk);
        #1 Invalidate = 1'b0;
      end
    join
    access(32'h11C, 0);
    // Round-robin replacement within set 0.
    do_reset(32'h000);
    push_beats(32'h000, 4); access(32'h000, 5);
    push_beats(32'h020, 4); access(32'h020, 5);
    push_beats(32'h040, 4); access(32'h040, 5);
    access(32'h020, 0);
    push_beats(32'h000, 4); access(32'h000, 5);
    access(32'h040, 0);
    push_beats(32'h020, 4); access(32'h020, 5);
    access(32'h000, 0);
    push_beats(32'h010, 4); access(32'h010, 5);
    access(32'h014, 0);
    // Reset after two beats abandons the burst; the line refills fully.
    push_beats(32'h200, 2);
    push_beats(32'h200, 4);
    fork
      access(32'h200, 9);
      begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
    join
    access(32'h20C, 0);
    push_beats(32'h000, 4); access(32'h000, 5);
  endtask

  task automatic sweeps();
    for (int k = 0; k < 2; k++) begin
      s_a[k]   = '0;
      s_req[k] = 1'b0;
    end
    sw_reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sw_reset = 1'b0;
    fork
      run_sweep(0, 256);
      run_sweep(1, 64);
    join
  endtask

  initial begin
    fork
      directed();
      sweeps();
    join
    repeat (2) @(posedge clk);
    tests += 4;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
    end
    if (addr_q.size() != 0) begin
      fails++;
      $display("FAIL beats_leftover: %0d beats remain, expected 0", addr_q.size());
    end
    if (exp0_q.size() != 0) begin
      fails++;
      $display("FAIL sweep0_leftover: %0d entries remain, expected 0", exp0_q.size());
    end
    if (exp1_q.size() != 0) begin
      fails++;
      $display("FAIL sweep1_leftover: %0d entries remain, expected 0", exp1_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_cache_nway.md
# instr_cache_nway

Parametrised N-way set-associative instruction cache for the pipelined ARM v4 core, sitting between the fetch stage and the AHB-style bus interface. It generalises the two-way, four-word-block instruction cache:
- way count, block size and set count are all parameters;
- replacement uses a per-set round-robin victim pointer;
- a whole-cache invalidate input is added;
- a miss is refilled as a sequential block burst.

Hits return in the same cycle. Misses stall fetch until the block is resident.

## Interface
- `blocksize`, 4: words per block; power of two, ≥2.
- `lines`, 2: sets; power of two, ≥1.
- `ways`, 2: associativity; 1, 2, 4 or 8.
- Derived: `setbits`=$clog2(lines), `blockbits`=$clog2(blocksize), `tagbits`=30-blockbits-setbits.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `A` in 32: fetch byte address; held stable by fetch while IStall=1.
- `Invalidate` in 1: one-cycle pulse; clear every valid bit.
- `BusReady` in 1: bus has accepted the current beat and HRData is valid this cycle.
- `HRData` in 32: bus read data.
- `RD` out 32: instruction word for A.
- `HAddrF` out 32: bus request address.
- `HRequestF` out 1: bus read request.
- `IStall` out 1: fetch must hold; RD not valid.

## Operation
- Address split: tag=A[31:32-tagbits], set=A[blockbits+setbits+1:blockbits+2], word=A[blockbits+1:2].
- State per way per set: valid bit, tag, blocksize×32 data. State per set: victim pointer of $clog2(ways) bits (0 bits when ways=1).

FSM has two states, LOOKUP and FILL.
- LOOKUP:
  - Hit = OR over ways of (valid & tag match). The hit way's word goes to RD; IStall=0 and HRequestF=0.
  - Multiple matching ways cannot occur; priority goes to the lowest way index.
  - On a miss, IStall=1 combinationally, Counter←0, and the FSM goes to FILL.
- FILL:
  - HRequestF=1 and IStall=1. HAddrF={A[31:blockbits+2], Counter, 2'b00}.
  - Victim way = victim pointer of the set, latched on entry.
  - Each cycle with BusReady=1: HRData is written into victim way word Counter, and Counter increments.
  - On the beat with Counter=blocksize-1:
    - write tag and set valid for the victim;
    - victim pointer ← pointer+1, mod ways;
    - go to LOOKUP.
  - BusReady=0 cycles hold all state.
- In LOOKUP, HAddrF=A and RD is cache data. In FILL, RD=HRData (bus forward, informational only, since IStall=1).
- Invalidate:
  - All valid bits clear at the next edge. Tags, data and victim pointers are retained.
  - If asserted during FILL, the fill aborts: no tag or valid write for that edge, the FSM returns to LOOKUP, and the beat on that edge is discarded.
  - Invalidate takes priority over a same-cycle last beat.
- Hit during LOOKUP never modifies the victim pointer. Replacement is round-robin, not LRU.

## Timing
- Hit latency 0: RD valid in the same cycle A is presented.
- Miss penalty, with BusReady asserted every FILL cycle: 1 detect cycle + blocksize beats, then the hit cycle.
  - For blocksize=4: IStall high 5 cycles, RD valid in the 6th.
- Reset, taking effect at the next edge:
  - FSM=LOOKUP, Counter=0, all valid=0, all victim pointers=0.
  - While reset is high: HRequestF=0, IStall=1.
  - Reset during FILL abandons the burst with no partial line marked valid.
- After reset, the first access is always a miss.
- Counter width is blockbits. It wraps only via the FILL→LOOKUP transition, never mid-burst.
- A must not change while IStall=1. Behaviour is undefined otherwise; the bench should assert this.

## Test plan
- Cold miss, ways=2, blocksize=4: A=0x100, BusReady=1 each cycle.
  - HAddrF steps 0x100, 0x104, 0x108, 0x10C.
  - IStall high 5 cycles; RD=mem[0x100] on cycle 6.
  - A=0x108 next cycle hits with RD=mem[0x108].
- Bus backpressure: same fill with BusReady low on beats 1 and 3. Counter and HAddrF hold, and IStall is extended by exactly 2 cycles.
- Round-robin, ways=2, lines=2: fill tags for 0x000, 0x020, 0x040 (same set 0).
  - 0x000 goes to way 0, 0x020 to way 1, 0x040 evicts way 0.
  - Re-access of 0x000 then misses and evicts way 1, while 0x040 still hits.
- Invalidate: after a fill of 0x100, pulse Invalidate, then access 0x100 → miss.
  - Pulse Invalidate on the last FILL beat → returns to LOOKUP, line not valid, re-miss.
- Reset mid-FILL: assert reset after 2 beats, release, then access the same A → full 4-beat refill with no stale hit.
- Parameter sweep: ways=1/blocksize=8/lines=4 and ways=4/blocksize=2/lines=1. Random address stream checked against a reference memory model; RD always matches when IStall=0.
